// File: rtl/sega_mapper_pkg.sv
// Shared constants and types for the Sega cartridge mapper: control register
// addresses, power-on bank values, read FSM states and slot classes.
package sega_mapper_pkg;

    localparam logic [15:0] ADDR_CTRL  = 16'hFFFC;
    localparam logic [15:0] ADDR_BANK0 = 16'hFFFD;
    localparam logic [15:0] ADDR_BANK1 = 16'hFFFE;
    localparam logic [15:0] ADDR_BANK2 = 16'hFFFF;

    localparam logic [7:0] RST_CTRL  = 8'h00;
    localparam logic [7:0] RST_BANK0 = 8'h00;
    localparam logic [7:0] RST_BANK1 = 8'h01;
    localparam logic [7:0] RST_BANK2 = 8'h02;

    localparam int CTRL_SRAM_EN   = 3;
    localparam int CTRL_SRAM_BANK = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROMWAIT  = 2'd1,
        ST_SRAMWAIT = 2'd2,
        ST_VALID    = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        SLOT_NONE = 2'd0,
        SLOT_ROM  = 2'd1,
        SLOT_SRAM = 2'd2
    } slot_t;

endpackage

// File: rtl/sega_mapper_regs.sv
// Mapper control registers (CTRL, BANK0-2) and the combinational slot decode
// that turns a Z80 address into a ROM address or a cartridge SRAM address.
module sega_mapper_regs
    import sega_mapper_pkg::*;
#(
    parameter int ROM_AW  = 22,
    parameter int SRAM_AW = 15
) (
    input  logic               MCLK,
    input  logic               RESET,
    input  logic               reg_we,
    input  logic [15:0]        address,
    input  logic [7:0]         data,
    input  logic [ROM_AW-1:0]  rom_mask,
    output slot_t              slot,
    output logic [ROM_AW-1:0]  rom_addr,
    output logic [SRAM_AW-1:0] sram_addr
);

    logic [7:0]  ctrl, bank0, bank1, bank2;
    logic [7:0]  bank;
    logic [21:0] rom_full;
    logic        unused_ctrl;

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            ctrl  <= RST_CTRL;
            bank0 <= RST_BANK0;
            bank1 <= RST_BANK1;
            bank2 <= RST_BANK2;
        end else if (reg_we) begin
            case (address)
                ADDR_CTRL:  ctrl  <= data;
                ADDR_BANK0: bank0 <= data;
                ADDR_BANK1: bank1 <= data;
                ADDR_BANK2: bank2 <= data;
                default: ;
            endcase
        end
    end

    // The first 1 KiB is pinned to bank 0 so the interrupt vectors survive paging.
    always_comb begin
        bank = 8'h00;
        slot = SLOT_NONE;
        if (address < 16'h0400) begin
            slot = SLOT_ROM;
        end else if (address < 16'h4000) begin
            bank = bank0;
            slot = SLOT_ROM;
        end else if (address < 16'h8000) begin
            bank = bank1;
            slot = SLOT_ROM;
        end else if (address < 16'hC000) begin
            if (ctrl[CTRL_SRAM_EN]) begin
                slot = SLOT_SRAM;
            end else begin
                bank = bank2;
                slot = SLOT_ROM;
            end
        end
    end

    assign rom_full    = {bank, address[13:0]};
    assign rom_addr    = ROM_AW'(rom_full) & rom_mask;
    assign sram_addr   = SRAM_AW'({ctrl[CTRL_SRAM_BANK], address[13:0]});
    assign unused_ctrl = ^{ctrl[7:4], ctrl[1:0]};

endmodule

// File: rtl/sega_mapper.sv
// Sega cartridge mapper top: strobe edge detection, SRAM write pulse and the
// read FSM that fetches from external ROM or cartridge SRAM.
module sega_mapper
    import sega_mapper_pkg::*;
#(
    parameter int ROM_AW  = 22,
    parameter int SRAM_AW = 15
) (
    input  logic               MCLK,
    input  logic               RESET,
    input  logic [15:0]        ADDRESS,
    input  logic [7:0]         DATA_i,
    input  logic               CART_CS,
    input  logic               CART_OE,
    input  logic               CART_WR,
    input  logic [ROM_AW-1:0]  ROM_MASK,
    output logic [7:0]         DATA_o,
    output logic               DATA_en,
    output logic [ROM_AW-1:0]  ROM_ADDR,
    output logic               ROM_REQ,
    input  logic               ROM_ACK,
    input  logic [7:0]         ROM_DATA,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE,
    output logic [7:0]         SRAM_D,
    input  logic [7:0]         SRAM_Q
);

    logic              cs_q, oe_q, wr_q, rd_p, wr_p;
    logic              rd_now, rd_start, wr_rise, launch;
    logic              en_q;
    logic [15:0]       addr_lat;
    rd_state_t         state;
    slot_t             slot;
    logic [ROM_AW-1:0] rom_addr;

    sega_mapper_regs #(
        .ROM_AW  (ROM_AW),
        .SRAM_AW (SRAM_AW)
    ) u_regs (
        .MCLK      (MCLK),
        .RESET     (RESET),
        .reg_we    (wr_rise),
        .address   (ADDRESS),
        .data      (DATA_i),
        .rom_mask  (ROM_MASK),
        .slot      (slot),
        .rom_addr  (rom_addr),
        .sram_addr (SRAM_ADDR)
    );

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            cs_q <= 1'b0;
            oe_q <= 1'b0;
            wr_q <= 1'b0;
            rd_p <= 1'b0;
            wr_p <= 1'b0;
        end else begin
            cs_q <= CART_CS;
            oe_q <= CART_OE;
            wr_q <= CART_WR;
            rd_p <= cs_q & oe_q;
            wr_p <= wr_q;
        end
    end

    assign rd_now   = cs_q & oe_q;
    assign rd_start = rd_now & ~rd_p;
    assign wr_rise  = wr_q & ~wr_p;
    assign SRAM_D   = DATA_i;

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) SRAM_WE <= 1'b0;
        else        SRAM_WE <= wr_rise & cs_q & (slot == SLOT_SRAM);
    end

    // A new fetch starts on a read edge, or when the address moves under held strobes.
    always_comb begin
        launch = ((state == ST_IDLE) && rd_start) ||
                 ((state == ST_VALID) && rd_now && (ADDRESS != addr_lat));
    end

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            DATA_o   <= 8'h00;
            en_q     <= 1'b0;
            ROM_REQ  <= 1'b0;
            ROM_ADDR <= '0;
            addr_lat <= 16'h0000;
        end else if (launch) begin
            en_q     <= 1'b0;
            addr_lat <= ADDRESS;
            case (slot)
                SLOT_ROM: begin
                    ROM_ADDR <= rom_addr;
                    ROM_REQ  <= 1'b1;
                    state    <= ST_ROMWAIT;
                end
                SLOT_SRAM: state <= ST_SRAMWAIT;
                default:   state <= ST_IDLE;
            endcase
        end else begin
            case (state)
                ST_ROMWAIT: if (ROM_ACK) begin
                    ROM_REQ <= 1'b0;
                    if (rd_now) begin
                        DATA_o <= ROM_DATA;
                        en_q   <= 1'b1;
                        state  <= ST_VALID;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_SRAMWAIT: begin
                    if (rd_now) begin
                        DATA_o <= SRAM_Q;
                        en_q   <= 1'b1;
                        state  <= ST_VALID;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_VALID: if (!rd_now) begin
                    en_q  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Gated with the live bus so the board never sees data for a stale or foreign cycle.
    assign DATA_en = en_q & CART_CS & CART_OE & (ADDRESS == addr_lat);

endmodule

// File: tb/tb_sega_mapper.sv
// Bench for sega_mapper: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic checked against a mapper model.
module tb_sega_mapper;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] ADDRESS = 16'h0000;
    logic [7:0]  DATA_i = 8'h00;
    logic        CART_CS = 1'b0, CART_OE = 1'b0, CART_WR = 1'b0;
    logic [21:0] ROM_MASK = 22'h07FFFF;
    logic [7:0]  DATA_o;
    logic        DATA_en;
    logic [21:0] ROM_ADDR;
    logic        ROM_REQ;
    logic        ROM_ACK = 1'b0;
    logic [7:0]  ROM_DATA = 8'h00;
    logic [14:0] SRAM_ADDR;
    logic        SRAM_WE;
    logic [7:0]  SRAM_D;
    logic [7:0]  SRAM_Q;

    sega_mapper #(.ROM_AW(22), .SRAM_AW(15)) dut (
        .MCLK(MCLK), .RESET(RESET), .ADDRESS(ADDRESS), .DATA_i(DATA_i),
        .CART_CS(CART_CS), .CART_OE(CART_OE), .CART_WR(CART_WR), .ROM_MASK(ROM_MASK),
        .DATA_o(DATA_o), .DATA_en(DATA_en), .ROM_ADDR(ROM_ADDR), .ROM_REQ(ROM_REQ),
        .ROM_ACK(ROM_ACK), .ROM_DATA(ROM_DATA), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE(SRAM_WE),
        .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
    );

    always #5 MCLK = ~MCLK;

    // External SRAM with one cycle of read latency
    logic [7:0] sram_mem [0:32767];
    always @(posedge MCLK) begin
        if (SRAM_WE === 1'b1) sram_mem[SRAM_ADDR] <= SRAM_D;
        SRAM_Q <= sram_mem[SRAM_ADDR];
    end

    int          we_cnt = 0;
    logic [14:0] last_wa = '0;
    logic [7:0]  last_wd = '0;
    always @(posedge MCLK) begin
        if (SRAM_WE === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            last_wa <= SRAM_ADDR;
            last_wd <= SRAM_D;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    // Reference model: mapper state and SRAM contents as plain variables
    logic [7:0] m_ctrl;
    logic [7:0] m_bank [3];
    logic [7:0] m_sram [0:32767];

    function automatic void model_reset();
        m_ctrl = 8'h00; m_bank[0] = 8'h00; m_bank[1] = 8'h01; m_bank[2] = 8'h02;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [7:0] d, input bit cs,
                                        output bit we, output logic [14:0] wa);
        we = 1'b0; wa = '0;
        if (a == 16'hFFFC) m_ctrl = d;
        else if (a == 16'hFFFD) m_bank[0] = d;
        else if (a == 16'hFFFE) m_bank[1] = d;
        else if (a == 16'hFFFF) m_bank[2] = d;
        else if (cs && a >= 16'h8000 && a < 16'hC000 && m_ctrl[3]) begin
            we = 1'b1;
            wa = 15'((m_ctrl[2] ? 16384 : 0) + int'(a) % 16384);
            m_sram[wa] = d;
        end
    endfunction

    // kind: 0 = no cartridge response, 1 = ROM, 2 = SRAM
    function automatic void model_read(input logic [15:0] a, output int kind,
                                       output logic [21:0] ra, output logic [14:0] sa);
        int bank;
        kind = 0; ra = '0; sa = '0; bank = 0;
        if (a >= 16'hC000) begin
            kind = 0;
        end else if (a >= 16'h8000 && m_ctrl[3]) begin
            kind = 2;
            sa = 15'((m_ctrl[2] ? 16384 : 0) + int'(a) % 16384);
        end else begin
            kind = 1;
            if (a < 16'h0400) bank = 0;
            else if (a < 16'h4000) bank = int'(m_bank[0]);
            else if (a < 16'h8000) bank = int'(m_bank[1]);
            else bank = int'(m_bank[2]);
            ra = 22'((bank * 16384 + int'(a) % 16384) & int'(ROM_MASK));
        end
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit cs,
                            output int n, output logic [14:0] wa, output logic [7:0] wd);
        int c0;
        c0 = we_cnt;
        ADDRESS = a; DATA_i = d; CART_CS = cs;
        tick();
        CART_WR = 1'b1;
        repeat (3) tick();
        CART_WR = 1'b0;
        repeat (3) tick();
        CART_CS = 1'b0;
        n = we_cnt - c0; wa = last_wa; wd = last_wd;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] rd, input int dly,
                           output bit req, output logic [21:0] ra, output bit en, output logic [7:0] dq);
        req = 1'b0; ra = '0; en = 1'b0; dq = '0;
        ADDRESS = a; CART_CS = 1'b1; CART_OE = 1'b1;
        for (int i = 0; i < 30 && !en; i++) begin
            tick();
            if (ROM_REQ && !req) begin
                req = 1'b1; ra = ROM_ADDR;
                repeat (dly) tick();
                ROM_DATA = rd; ROM_ACK = 1'b1;
                tick();
                ROM_ACK = 1'b0;
                chk("req_clear_on_ack", 32'(ROM_REQ), 32'd0);
            end
            if (DATA_en) begin en = 1'b1; dq = DATA_o; end
        end
        if (en) begin
            tick(); tick();
            chk("en_hold", 32'(DATA_en), 32'd1);
        end
        CART_OE = 1'b0;
        tick();
        chk("en_drop", 32'(DATA_en), 32'd0);
        CART_CS = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_req(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (ROM_REQ) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic ack(input logic [7:0] d);
        ROM_DATA = d; ROM_ACK = 1'b1;
        tick();
        ROM_ACK = 1'b0;
    endtask

    typedef struct {
        bit          rd;
        logic [15:0] a;
        logic [7:0]  d;
        bit          exp_req;
        logic [21:0] exp_ra;
        bit          exp_en;
        logic [7:0]  exp_dq;
        bit          exp_we;
        logic [14:0] exp_wa;
    } vec_t;

    vec_t        vt [13];
    bit          req, en, mwe;
    logic [21:0] ra, mra;
    logic [7:0]  dq, wd;
    logic [14:0] wa, mwa, msa;
    int          wn, kind;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 16'h4123, 8'h5A, 1'b1, 22'h004123, 1'b1, 8'h5A, 1'b0, 15'h0000};
        vt[1]  = '{1'b0, 16'hFFFF, 8'h85, 1'b0, 22'h000000, 1'b0, 8'h00, 1'b0, 15'h0000};
        vt[2]  = '{1'b1, 16'h8010, 8'h11, 1'b1, 22'h014010, 1'b1, 8'h11, 1'b0, 15'h0000};
        vt[3]  = '{1'b0, 16'hFFFD, 8'h07, 1'b0, 22'h000000, 1'b0, 8'h00, 1'b0, 15'h0000};
        vt[4]  = '{1'b1, 16'h0200, 8'h22, 1'b1, 22'h000200, 1'b1, 8'h22, 1'b0, 15'h0000};
        vt[5]  = '{1'b1, 16'h0400, 8'h33, 1'b1, 22'h01C400, 1'b1, 8'h33, 1'b0, 15'h0000};
        vt[6]  = '{1'b0, 16'hFFFC, 8'h0C, 1'b0, 22'h000000, 1'b0, 8'h00, 1'b0, 15'h0000};
        vt[7]  = '{1'b0, 16'h9001, 8'hA0, 1'b0, 22'h000000, 1'b0, 8'h00, 1'b1, 15'h5001};
        vt[8]  = '{1'b1, 16'h9001, 8'h00, 1'b0, 22'h000000, 1'b1, 8'hA0, 1'b0, 15'h0000};
        vt[9]  = '{1'b0, 16'hFFFC, 8'h00, 1'b0, 22'h000000, 1'b0, 8'h00, 1'b0, 15'h0000};
        vt[10] = '{1'b0, 16'h9001, 8'h55, 1'b0, 22'h000000, 1'b0, 8'h00, 1'b0, 15'h0000};
        vt[11] = '{1'b1, 16'h9001, 8'h44, 1'b1, 22'h015001, 1'b1, 8'h44, 1'b0, 15'h0000};
        vt[12] = '{1'b1, 16'hC000, 8'h66, 1'b0, 22'h000000, 1'b0, 8'h00, 1'b0, 15'h0000};

        for (int i = 0; i < 32768; i++) begin
            sram_mem[i] = 8'h00;
            m_sram[i] = 8'h00;
        end
        model_reset();

        // Reset state
        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_rom_req", 32'(ROM_REQ), 32'd0);
        chk("rst_data_en", 32'(DATA_en), 32'd0);
        chk("rst_data_o", 32'(DATA_o), 32'h00);
        chk("rst_sram_we", 32'(SRAM_WE), 32'd0);
        RESET = 1'b1;
        repeat (2) tick();

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            if (vt[i].rd) begin
                do_read(vt[i].a, vt[i].d, 3, req, ra, en, dq);
                chk($sformatf("v%0d_req", i), 32'(req), 32'(vt[i].exp_req));
                if (vt[i].exp_req) chk($sformatf("v%0d_rom_addr", i), 32'(ra), 32'(vt[i].exp_ra));
                chk($sformatf("v%0d_en", i), 32'(en), 32'(vt[i].exp_en));
                if (vt[i].exp_en) chk($sformatf("v%0d_data", i), 32'(dq), 32'(vt[i].exp_dq));
            end else begin
                model_write(vt[i].a, vt[i].d, 1'b1, mwe, mwa);
                do_write(vt[i].a, vt[i].d, 1'b1, wn, wa, wd);
                chk($sformatf("v%0d_we_count", i), 32'(wn), 32'(vt[i].exp_we));
                if (vt[i].exp_we) begin
                    chk($sformatf("v%0d_sram_addr", i), 32'(wa), 32'(vt[i].exp_wa));
                    chk($sformatf("v%0d_sram_d", i), 32'(wd), 32'(vt[i].d));
                end
            end
        end

        // Address change under held strobes restarts the fetch
        ADDRESS = 16'h4000; CART_CS = 1'b1; CART_OE = 1'b1;
        model_read(16'h4000, kind, mra, msa);
        wait_req("chg_req1");
        chk("chg_addr1", 32'(ROM_ADDR), 32'(mra));
        ack(8'h61);
        chk("chg_en1", 32'(DATA_en), 32'd1);
        chk("chg_data1", 32'(DATA_o), 32'h61);
        ADDRESS = 16'h4001;
        #1;
        chk("chg_en_low", 32'(DATA_en), 32'd0);
        model_read(16'h4001, kind, mra, msa);
        wait_req("chg_req2");
        chk("chg_addr2", 32'(ROM_ADDR), 32'(mra));
        ack(8'h62);
        chk("chg_en2", 32'(DATA_en), 32'd1);
        chk("chg_data2", 32'(DATA_o), 32'h62);
        CART_OE = 1'b0; CART_CS = 1'b0;
        repeat (3) tick();

        // Read abandoned while waiting on ROM
        ADDRESS = 16'h4010; CART_CS = 1'b1; CART_OE = 1'b1;
        wait_req("abort_req");
        CART_OE = 1'b0;
        repeat (4) tick();
        chk("abort_req_held", 32'(ROM_REQ), 32'd1);
        chk("abort_en", 32'(DATA_en), 32'd0);
        ack(8'h77);
        chk("abort_req_clear", 32'(ROM_REQ), 32'd0);
        CART_CS = 1'b0;
        repeat (3) tick();
        do_read(16'h4010, 8'h78, 1, req, ra, en, dq);
        chk("abort_next_en", 32'(en), 32'd1);
        chk("abort_next_data", 32'(dq), 32'h78);

        // Stray ACK in IDLE
        ack(8'hEE);
        tick();
        chk("stray_en", 32'(DATA_en), 32'd0);
        chk("stray_req", 32'(ROM_REQ), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 150; k++) begin
            int op;
            logic [15:0] a;
            logic [7:0] d;
            bit cs;
            op = int'($urandom_range(0, 9));
            d = 8'($urandom);
            cs = 1'($urandom_range(0, 1));
            if (op < 3) begin
                a = 16'hFFFC + 16'($urandom_range(0, 3));
                model_write(a, d, cs, mwe, mwa);
                do_write(a, d, cs, wn, wa, wd);
                chk("rnd_reg_we", 32'(wn), 32'd0);
            end else if (op < 5) begin
                if ($urandom_range(0, 1) == 1) a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
                else a = 16'($urandom_range(0, 16'hFFFB));
                model_write(a, d, cs, mwe, mwa);
                do_write(a, d, cs, wn, wa, wd);
                chk("rnd_we_count", 32'(wn), 32'(mwe));
                if (mwe) begin
                    chk("rnd_sram_addr", 32'(wa), 32'(mwa));
                    chk("rnd_sram_d", 32'(wd), 32'(d));
                end
            end else begin
                case ($urandom_range(0, 3))
                    0: a = 16'($urandom_range(0, 16'h03FF));
                    1: a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
                    2: a = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
                    default: a = 16'($urandom_range(0, 16'hFFFF));
                endcase
                model_read(a, kind, mra, msa);
                do_read(a, d, int'($urandom_range(0, 8)), req, ra, en, dq);
                chk($sformatf("rnd_req_%h", a), 32'(req), 32'(kind == 1));
                if (kind == 1) chk($sformatf("rnd_rom_addr_%h", a), 32'(ra), 32'(mra));
                chk($sformatf("rnd_en_%h", a), 32'(en), 32'(kind != 0));
                if (kind == 1) chk($sformatf("rnd_rom_data_%h", a), 32'(dq), 32'(d));
                if (kind == 2) chk($sformatf("rnd_sram_data_%h", a), 32'(dq), 32'(m_sram[msa]));
            end
        end

        // Reset in the middle of a ROM request
        do_write(16'hFFFE, 8'h09, 1'b1, wn, wa, wd);
        ADDRESS = 16'h4000; CART_CS = 1'b1; CART_OE = 1'b1;
        wait_req("rst_mid_req");
        #2;
        RESET = 1'b0;
        #1;
        chk("rst_async_req", 32'(ROM_REQ), 32'd0);
        CART_CS = 1'b0; CART_OE = 1'b0;
        tick();
        RESET = 1'b1;
        model_reset();
        tick();
        ack(8'h99);
        tick();
        chk("rst_late_ack_en", 32'(DATA_en), 32'd0);
        chk("rst_late_ack_req", 32'(ROM_REQ), 32'd0);
        do_read(16'h0500, 8'h01, 0, req, ra, en, dq);
        chk("rst_bank0", 32'(ra), 32'h000500);
        do_read(16'h4500, 8'h02, 0, req, ra, en, dq);
        chk("rst_bank1", 32'(ra), 32'h004500);
        do_read(16'h8500, 8'h03, 0, req, ra, en, dq);
        chk("rst_bank2_req", 32'(req), 32'd1);
        chk("rst_bank2", 32'(ra), 32'h008500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
